// File: rtl/ospfb_sequencer_if.sv
// ospfb_sequencer_if -- bundle of the sequencer's datapath, AXI-stream,
// FFT-config, FFT-event and status signals.
//
// Handshake rules (valid/ready):
//   - A transfer happens in the cycle where valid and ready are both high.
//   - s_axis: a word is consumed when s_axis_tvalid & s_axis_tready.
//     s_axis_tready never depends on s_axis_tvalid.
//   - cfg: cfg_tvalid stays high with a stable cfg_tdata until the
//     cfg_tvalid & cfg_tready cycle. It then drops on the next cycle.
//   - m_axis_tready is a plain gate on the datapath step. One datapath step
//     (dp_ce) produces exactly one FFT input word.
//
// Modports:
//   master : the sequencer side (drives the control and status signals)
//   slave  : the datapath/FFT/upstream side
//
// Parameter PC_W : width of pc_offset, $clog2(FFT_LEN)
interface ospfb_sequencer_if #(
  parameter int PC_W = 7
);
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic            m_axis_tready;
  logic            dp_ce;
  logic            dp_hold_rst;
  logic            din_new;
  logic [PC_W-1:0] pc_offset;
  logic            frame_tlast;
  logic            cfg_tvalid;
  logic [15:0]     cfg_tdata;
  logic            cfg_tready;
  logic            event_tlast_unexpected;
  logic            event_tlast_missing;
  logic            event_fft_overflow;
  logic [2:0]      err_sticky;
  logic [31:0]     frame_ctr;
  logic [2:0]      state;

  modport master (
    input  s_axis_tvalid, m_axis_tready, cfg_tready,
           event_tlast_unexpected, event_tlast_missing, event_fft_overflow,
    output s_axis_tready, dp_ce, dp_hold_rst, din_new, pc_offset, frame_tlast,
           cfg_tvalid, cfg_tdata, err_sticky, frame_ctr, state
  );

  modport slave (
    output s_axis_tvalid, m_axis_tready, cfg_tready,
           event_tlast_unexpected, event_tlast_missing, event_fft_overflow,
    input  s_axis_tready, dp_ce, dp_hold_rst, din_new, pc_offset, frame_tlast,
           cfg_tvalid, cfg_tdata, err_sticky, frame_ctr, state
  );
endinterface

// File: rtl/ospfb_sequencer.sv
// ospfb_sequencer -- control-path sequencer for the oversampled PFB datapath.
//
// Operating sequence:
//   1. Bring the datapath out of reset and flush it with zeros.
//   2. Issue the FFT configuration word.
//   3. For each output frame, pace FFT_LEN/SAMP_PER_CLK datapath steps.
//      The first DEC_FAC/SAMP_PER_CLK steps consume a new input word.
//      The remaining steps recirculate.
//   4. Track the phase-compensation rotation offset and frame tlast.
//   5. Latch FFT error events.
//
// Ports:
//   clk, rstn : clock and synchronous active-low reset
//   en        : run enable (starts the sequence; pauses RUN in place)
//   bus       : ospfb_sequencer_if.master
//               s_axis / m_axis_tready   : step pacing
//               dp_ce, dp_hold_rst       : datapath control
//               din_new                  : new input or recirculate
//               pc_offset, frame_tlast   : phase compensation and frame marker
//               cfg_*                    : FFT config
//               event_*                  : FFT events
//               err_sticky, frame_ctr    : status
//               state                    : FSM state for debug
//
// Optional macro OSPFB_SEQ_OVFL_HALT_EN:
//   When defined, an FFT overflow event during RUN also halts into ERR.
module ospfb_sequencer #(
  parameter int          FFT_LEN      = 128,
  parameter int          DEC_FAC      = 96,
  parameter int          PTAPS        = 8,
  parameter int          SAMP_PER_CLK = 2,
  parameter logic [15:0] CFG_WORD     = 16'h0001
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  ospfb_sequencer_if.master bus
);

  localparam int PCW     = $clog2(FFT_LEN);
  localparam int L       = FFT_LEN / SAMP_PER_CLK;
  localparam int D       = DEC_FAC / SAMP_PER_CLK;
  localparam int FLUSH_N = FFT_LEN * PTAPS / SAMP_PER_CLK;
  localparam int KW      = (L > 1) ? $clog2(L) : 1;
  localparam int FW      = (FLUSH_N > 1) ? $clog2(FLUSH_N) : 1;

  localparam logic [KW-1:0] K_LAST     = KW'(L - 1);
  localparam logic [KW:0]   D_LIM      = (KW + 1)'(D);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_N - 1);
  localparam logic [PCW:0]  LEN_W      = (PCW + 1)'(FFT_LEN);
  localparam logic [PCW:0]  DEC_W      = (PCW + 1)'(DEC_FAC % FFT_LEN);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    WAITFFT = 3'd2,
    RUN     = 3'd3,
    ERR     = 3'd4
  } state_t;

  state_t          st;
  logic [FW-1:0]   flush_ctr;
  logic [KW-1:0]   k;
  logic [PCW-1:0]  pc;
  logic            cfg_valid_q;
  logic            hold_rst_q;
  logic [2:0]      err_q;
  logic [31:0]     frame_q;

  logic            din_new;
  logic            run_step;
  logic            halt_evt;
  logic [PCW:0]    pc_sum;
  logic [PCW:0]    pc_wrap;
  logic [2:0]      evt_vec;

  assign evt_vec = {bus.event_fft_overflow, bus.event_tlast_missing,
                    bus.event_tlast_unexpected};

`ifdef OSPFB_SEQ_OVFL_HALT_EN
  assign halt_evt = bus.event_tlast_unexpected | bus.event_tlast_missing |
                    bus.event_fft_overflow;
`else
  assign halt_evt = bus.event_tlast_unexpected | bus.event_tlast_missing;
`endif

  // The new-input window is the first D steps of every frame.
  assign din_new = (st == RUN) && ({1'b0, k} < D_LIM);

  // A recirculate step needs no upstream word, so only new-input steps wait
  // on s_axis_tvalid.
  assign run_step = (st == RUN) && en && bus.m_axis_tready &&
                    (!din_new || bus.s_axis_tvalid);

  // Both operands are below FFT_LEN, so one conditional subtract gives the
  // modulo. This also holds when FFT_LEN is not a power of two.
  assign pc_sum  = {1'b0, pc} + DEC_W;
  assign pc_wrap = (pc_sum >= LEN_W) ? (pc_sum - LEN_W) : pc_sum;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st          <= IDLE;
      flush_ctr   <= '0;
      k           <= '0;
      pc          <= '0;
      cfg_valid_q <= 1'b0;
      hold_rst_q  <= 1'b1;
      err_q       <= 3'b000;
      frame_q     <= 32'd0;
    end else begin
      err_q <= err_q | evt_vec;
      case (st)
        IDLE: begin
          hold_rst_q <= 1'b1;
          if (en) begin
            st        <= INIT;
            flush_ctr <= '0;
          end
        end
        INIT: begin
          if (flush_ctr == FLUSH_LAST) begin
            st          <= WAITFFT;
            hold_rst_q  <= 1'b0;
            cfg_valid_q <= 1'b1;
          end else begin
            flush_ctr <= flush_ctr + 1'b1;
          end
        end
        WAITFFT: begin
          if (cfg_valid_q && bus.cfg_tready) begin
            cfg_valid_q <= 1'b0;
            st          <= RUN;
          end
        end
        RUN: begin
          // A step issued in the same cycle as a halting event still took
          // place downstream, so the counters account for it.
          if (run_step) begin
            if (k == K_LAST) begin
              k       <= '0;
              frame_q <= frame_q + 32'd1;
              pc      <= pc_wrap[PCW-1:0];
            end else begin
              k <= k + 1'b1;
            end
          end
          if (halt_evt) st <= ERR;
        end
        ERR: begin
          st <= ERR;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.dp_ce         = (st == INIT) || run_step;
  assign bus.dp_hold_rst   = hold_rst_q;
  assign bus.din_new       = din_new;
  assign bus.s_axis_tready = (st == RUN) && en && din_new && bus.m_axis_tready;
  assign bus.frame_tlast   = (k == K_LAST);
  assign bus.pc_offset     = pc;
  assign bus.cfg_tvalid    = cfg_valid_q;
  assign bus.cfg_tdata     = CFG_WORD;
  assign bus.err_sticky    = err_q;
  assign bus.frame_ctr     = frame_q;
  assign bus.state         = st;

endmodule

// File: doc/ospfb_sequencer.md
Name: ospfb_sequencer

Overview:
Control-path sequencer for the oversampled PFB datapath (delay lines, polyphase FIR, phase compensation, FFT). Takes the datapath out of reset and flushes it, issues the FFT configuration word, then per output frame paces the FFT_LEN/SAMP_PER_CLK datapath steps: only DEC_FAC/SAMP_PER_CLK of those steps consume new input, the rest recirculate. Drives the phase-compensation rotation offset and frame tlast, and latches FFT error events.

Parameters:
FFT_LEN, 128, polyphase branches / FFT points; must be a multiple of SAMP_PER_CLK
DEC_FAC, 96, decimation factor; DEC_FAC < FFT_LEN and a multiple of SAMP_PER_CLK
PTAPS, 8, polyphase taps per branch; sets the flush length
SAMP_PER_CLK, 2, samples per datapath word
CFG_WORD, 16'h0001, FFT config tdata (fwd/inv bit plus scaling schedule)

Ports:
clk  in  1  DSP clock
rstn  in  1  synchronous active-low reset
en  in  1  run enable
s_axis_tvalid  in  1  upstream sample word valid
s_axis_tready  out  1  upstream ready
m_axis_tready  in  1  FFT data input ready
dp_ce  out  1  datapath step enable
dp_hold_rst  out  1  datapath hold-in-reset/flush
din_new  out  1  1=consume new input word this step, 0=recirculate
pc_offset  out  $clog2(FFT_LEN)  phase-compensation rotation offset for current frame
frame_tlast  out  1  last step of frame (to FFT tlast)
cfg_tvalid  out  1  FFT config valid
cfg_tdata  out  16  FFT config word (= CFG_WORD)
cfg_tready  in  1  FFT config ready
event_tlast_unexpected  in  1  FFT event
event_tlast_missing  in  1  FFT event
event_fft_overflow  in  1  FFT event
err_sticky  out  3  {overflow, missing, unexpected} latched
frame_ctr  out  32  completed frames
state  out  3  FSM state for debug

Behaviour:
- States: IDLE(0), INIT(1), WAITFFT(2), RUN(3), ERR(4).
- Reset (rstn=0 at posedge, any state incl. mid-frame): state=IDLE; dp_ce=0, dp_hold_rst=1, din_new=0, pc_offset=0, frame_tlast=0, cfg_tvalid=0, err_sticky=0, frame_ctr=0, internal step counter=0.
- IDLE: dp_hold_rst=1; en=1 -> INIT.
- INIT: dp_hold_rst=1, dp_ce=1 for exactly FFT_LEN*PTAPS/SAMP_PER_CLK cycles (zero-flush), then -> WAITFFT. en ignored.
- WAITFFT: dp_hold_rst=0, dp_ce=0, cfg_tvalid=1 held until cfg_tvalid&cfg_tready, then cfg_tvalid=0 next cycle, -> RUN.
- RUN: L=FFT_LEN/SAMP_PER_CLK steps/frame, D=DEC_FAC/SAMP_PER_CLK. step counter k in 0..L-1; din_new = (k < D), combinational from k.
- s_axis_tready = (state==RUN) & en & din_new & m_axis_tready.
- dp_ce = (state==RUN) & en & m_axis_tready & (~din_new | s_axis_tvalid). Combinational; same-cycle handshake, zero latency.
- On dp_ce: k increments; at k=L-1 frame_tlast=1 (combinational, qualified by k only), k wraps to 0, frame_ctr++, pc_offset <= (pc_offset + DEC_FAC) mod FFT_LEN (sequence 0,96,64,32,0... for defaults).
- No dp_ce (stall, en=0, or starved on new-input step): all counters hold; recirculate steps never stall on s_axis_tvalid.
- en=0 in RUN: freeze in place, resume same k/pc_offset on en=1.
- Events: any event input high in any state -> corresponding err_sticky bit set next cycle, cleared only by reset. Simultaneous events set all bits.
- event_tlast_unexpected or event_tlast_missing in RUN -> ERR. ERR: dp_ce=0, s_axis_tready=0, dp_hold_rst=0, outputs hold; exits only via rstn.
- frame_ctr wraps at 2^32.

Optional Feature:
OSPFB_SEQ_OVFL_HALT_EN: when defined, event_fft_overflow in RUN also transitions to ERR. When undefined, overflow only sets err_sticky[2]; RUN continues.

Test Plan:
- Reset then en=1 (FFT_LEN=8,DEC_FAC=6,PTAPS=2,SPC=2) -> INIT lasts exactly 8 cycles with dp_hold_rst=1,dp_ce=1, then WAITFFT with cfg_tvalid=1, cfg_tdata=16'h0001.
- cfg_tready held low 5 cycles then pulsed -> cfg_tvalid drops next cycle, state=RUN, no dp_ce before.
- RUN, tvalid=1, m_tready=1 -> per 4 steps din_new pattern 1,1,1,0, s_axis_tready follows; frame_tlast on step 4; pc_offset 0,6,4,2,0 across frames; frame_ctr=5 after 20 steps.
- Drop s_axis_tvalid at k=1 for 3 cycles -> dp_ce=0, k holds; drop at k=3 -> dp_ce stays 1 (recirculate); m_tready=0 -> dp_ce=0 and s_axis_tready=0.
- event_tlast_missing pulse in RUN -> err_sticky=3'b010, state=ERR, dp_ce=0 permanently; overflow pulse -> err_sticky[2]=1, ERR only with OSPFB_SEQ_OVFL_HALT_EN.
- rstn=0 mid-frame at k=2 -> next cycle all outputs at reset values, state=IDLE; re-run starts pc_offset=0, k=0.
